// File: rtl/neopixel_frame_sequencer.sv
// Frame buffer and sequencer that feeds a WS2812 serialiser over a valid/busy
// handshake, then holds the line idle for the latch gap before signalling done.
module neopixel_frame_sequencer #(
  parameter int NUM_PIXELS = 10,
  parameter int CLK_HZ     = 12_000_000,
  parameter int LATCH_US   = 80,
  parameter int AW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [23:0]   i_wr_data,
  input  logic          i_start,
  output logic [7:0]    o_red,
  output logic [7:0]    o_green,
  output logic [7:0]    o_blue,
  output logic          o_valid,
  input  logic          i_busy,
  output logic          o_frame_busy,
  output logic          o_frame_done
);

  localparam int LATCH_CYCLES = CLK_HZ / 1_000_000 * LATCH_US;
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_PIXELS - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, LATCH} state_t;

  state_t        state;
  state_t        state_next;
  logic [23:0]   mem [NUM_PIXELS];
  logic [AW-1:0] index;
  logic [LW-1:0] latch_cnt;
  logic          pending;
  logic          accept;

  // Frame buffer write port has no reset so the colour data survives a reset.
  always_ff @(posedge CLK) begin
    if (i_wr_en && (int'(i_wr_addr) < NUM_PIXELS)) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      index        <= '0;
      latch_cnt    <= '0;
      pending      <= 1'b0;
      o_red        <= 8'h00;
      o_green      <= 8'h00;
      o_blue       <= 8'h00;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_next;
      o_frame_done <= (state == LATCH) && (latch_cnt == LATCH_LAST);

      // A new request wins over the clear so a start is never lost.
      if (i_start) begin
        pending <= 1'b1;
      end else if (accept) begin
        pending <= 1'b0;
      end

      if (state == IDLE) begin
        index <= '0;
      end else if ((state == WAIT) && !i_busy && (index != LAST_IDX)) begin
        index <= index + 1'b1;
      end

      if (state == LOAD) begin
        {o_red, o_green, o_blue} <= mem[index];
      end

      if (state == LATCH) begin
        latch_cnt <= latch_cnt + 1'b1;
      end else begin
        latch_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (pending && !i_busy) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: state_next = SEND;
      SEND: begin
        if (i_busy) state_next = WAIT;
      end
      WAIT: begin
        if (!i_busy) state_next = (index == LAST_IDX) ? LATCH : LOAD;
      end
      LATCH: begin
        if (latch_cnt == LATCH_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_valid      = (state == SEND);
  assign o_frame_busy = (state != IDLE);

endmodule

// File: doc/neopixel_frame_sequencer.md
# neopixel_frame_sequencer

Upstream feeder for the `writepixel` serialiser in the NeoPixel PMOD design. It holds a small colour frame buffer of `NUM_PIXELS` 24-bit entries, written by the host logic. On a start request it streams every entry, in address order, to `writepixel` over the valid/busy handshake. After the last pixel it holds the line idle for the WS2812 latch/reset period and then reports the frame complete.

## Interface
Parameters:
- `NUM_PIXELS`, 10: pixels per frame, range 1–256.
- `CLK_HZ`, 12_000_000: system clock frequency.
- `LATCH_US`, 80: latch gap after the last pixel. `LATCH_CYCLES = CLK_HZ/1_000_000*LATCH_US` (960 at defaults).
- `AW`, `$clog2(NUM_PIXELS)` with a minimum of 1: address width (derived).

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST_N`  in  1  reset, synchronous, active-low.
- `i_wr_en`  in  1  frame-buffer write strobe.
- `i_wr_addr`  in  AW  write address; writes with address ≥ `NUM_PIXELS` are dropped.
- `i_wr_data`  in  24  colour `{red[23:16], green[15:8], blue[7:0]}`.
- `i_start`  in  1  frame request, sampled on every clock.
- `o_red`, `o_green`, `o_blue`  out  8 each  colour driven to `writepixel`.
- `o_valid`  out  1  pixel request to `writepixel`.
- `i_busy`  in  1  `writepixel` busy.
- `o_frame_busy`  out  1  high from frame acceptance through the end of LATCH.
- `o_frame_done`  out  1  one-cycle pulse when the latch gap completes.

## Operation
- Frame buffer:
  - `NUM_PIXELS`×24 synchronous RAM with one write port and one registered read port.
  - The RAM is not cleared by reset.
  - Writes are accepted in every state.
  - A write to a pixel that has already been read for the current frame takes effect in the next frame.
- States: IDLE, LOAD, SEND, WAIT, LATCH.
  - IDLE: `o_valid`=0. Enters LOAD, with index=0, when a start is pending and `i_busy`=0.
  - LOAD: one cycle. Issues the RAM read for the current index and captures the result into the `o_red`/`o_green`/`o_blue` registers on exit. Goes to SEND.
  - SEND: `o_valid`=1. Stays in SEND until `i_busy`=1 is sampled, then goes to WAIT. `o_valid` is low in the cycle after `i_busy` is sampled high.
  - WAIT: `o_valid`=0. Stays until `i_busy`=0 is sampled. Then goes to LOAD with index+1, or to LATCH if index = `NUM_PIXELS`-1.
  - LATCH: counts `LATCH_CYCLES` cycles with `o_valid`=0. On the final count it pulses `o_frame_done` and returns to IDLE.
- Start handling:
  - `i_start` sets a one-deep pending flag. The flag is cleared when IDLE→LOAD is taken.
  - A start received while `o_frame_busy`=1 queues exactly one further frame; additional starts in that window are merged into it.
  - A start and a frame completion in the same cycle: the pending flag is set and the next frame begins.
- Colour outputs change only on LOAD exit. They are stable from `o_valid` rising until `i_busy` falls.
- Index is an `AW`-bit counter. It never wraps within a frame; the terminal compare against `NUM_PIXELS`-1 ends the frame.
- Reset (`RST_N`=0 at a clock edge):
  - Output values after reset: state IDLE, `o_valid`=0, `o_frame_busy`=0, `o_frame_done`=0, `o_red`/`o_green`/`o_blue`=0.
  - Index, latch counter and pending flag are cleared.
  - Reset mid-frame abandons the frame with no `o_frame_done` pulse.
  - The next frame starts only once `i_busy`=0, so a serialiser still shifting when reset occurred is never re-requested early.

## Timing
- `i_start` sampled at edge 0 with the block idle and `i_busy`=0: LOAD occupies cycle 1, `o_valid` and the colour appear after edge 2.
- Write-to-read: data written at edge n is visible to a LOAD at edge n+1 or later.
- Pixel loop: `i_busy` falling, as sampled, to the next `o_valid` rise is 2 cycles (WAIT→LOAD→SEND).
- `o_frame_busy` rises the cycle after start acceptance. It falls in the same cycle `o_frame_done` pulses.
- Frame length = `NUM_PIXELS`×(serialiser time + 3) + `LATCH_CYCLES` + 1 cycles.

## Test plan
- Reset and idle:
  - Stimulus: hold `RST_N`=0 for 4 clocks, release, with no start.
  - Required: all outputs stay 0 indefinitely.
- Single frame, defaults, busy model asserting 1 cycle after valid and holding 30 cycles:
  - Stimulus: write address k = {8'h20·(k+1) mod 256, 8'hk, 8'h00}, then pulse start.
  - Required: 10 valid pulses with colours in address order; `o_frame_done` exactly `LATCH_CYCLES`+1 cycles after the last busy fall; `o_valid`=0 throughout LATCH.
- Queued start:
  - Stimulus: pulse `i_start` three times during frame 1.
  - Required: exactly one extra frame follows; 20 valid pulses in total; 2 done pulses.
- Write during frame:
  - Stimulus: rewrite address 0 with 24'hFFFFFF while pixel 5 is sent; rewrite address 9 with 24'h0000FF before pixel 9 loads.
  - Required: pixel 0 keeps its old value this frame; pixel 9 = 0/0/FF; the next frame shows pixel 0 = FF/FF/FF.
- Out-of-range write: write address 12 with `NUM_PIXELS`=10.
  - Required: RAM contents unchanged; frame output identical to the previous frame.
- Reset mid-frame:
  - Stimulus: assert `RST_N` low during WAIT of pixel 4 while `i_busy`=1, then release and pulse start with `i_busy` still high.
  - Required: no `o_frame_done` pulse; `o_valid` stays 0 until `i_busy` falls; the restarted frame begins at pixel 0.
